// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - instruction decode stage: register file, load-use stall, ID/EX register, halt FSM
module decode_pipe #(
    parameter int LEN          = 32,
    parameter int NREG         = 32,
    parameter int CTRL_W       = 22,
    parameter int MEM_READ_BIT = 3,
    localparam int NB          = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LEN-1:0]    in_pc,
    input  logic [LEN-1:0]    in_instruccion,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_halt,
    input  logic              flush,
    input  logic              RegWrite,
    input  logic [NB-1:0]     write_register,
    input  logic [LEN-1:0]    write_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LEN-1:0]    out_pc,
    output logic [LEN-1:0]    out_reg1,
    output logic [LEN-1:0]    out_reg2,
    output logic [LEN-1:0]    out_sign_extend,
    output logic [NB-1:0]     out_rs,
    output logic [NB-1:0]     out_rt,
    output logic [NB-1:0]     out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              stall_flag,
    output logic              out_halt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LEN-1:0]     regs_q [NREG];

    logic               valid_q, valid_d;
    logic [LEN-1:0]     pc_q, pc_d;
    logic [LEN-1:0]     reg1_q, reg1_d;
    logic [LEN-1:0]     reg2_q, reg2_d;
    logic [LEN-1:0]     sext_q, sext_d;
    logic [NB-1:0]      rs_q, rs_d;
    logic [NB-1:0]      rt_q, rt_d;
    logic [NB-1:0]      rd_q, rd_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               halt_q, halt_d;

    logic [NB-1:0]      rs_f, rt_f, rd_f;
    logic [LEN-1:0]     rdata1, rdata2, sext;
    logic               hazard, load_en, accept, stall;

    assign rs_f = in_instruccion[21 +: NB];
    assign rt_f = in_instruccion[16 +: NB];
    assign rd_f = in_instruccion[11 +: NB];
    assign sext = {{(LEN-16){in_instruccion[15]}}, in_instruccion[15:0]};

    // Register 0 is hardwired to zero; a same-cycle writeback is forwarded to the read ports.
    always_comb begin
        rdata1 = regs_q[rs_f];
        if (rs_f == '0)
            rdata1 = '0;
        else if (RegWrite && (write_register == rs_f))
            rdata1 = write_data;
    end

    always_comb begin
        rdata2 = regs_q[rt_f];
        if (rt_f == '0)
            rdata2 = '0;
        else if (RegWrite && (write_register == rt_f))
            rdata2 = write_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (RegWrite && (write_register != '0)) begin
            regs_q[write_register] <= write_data;
        end
    end

    assign hazard   = valid_q && ctrl_q[MEM_READ_BIT] && (rt_q != '0) &&
                      ((rt_q == rs_f) || (rt_q == rt_f));
    assign load_en  = !valid_q || out_ready;
    assign in_ready = load_en && !hazard && (state_q == RUN) && !flush;
    assign accept   = in_valid && in_ready;
    assign stall    = load_en && hazard && (state_q == RUN) && !flush;

    // Flush outranks everything; otherwise the ID/EX register only moves when execute can take it.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        reg1_d  = reg1_q;
        reg2_d  = reg2_q;
        sext_d  = sext_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_en) begin
            if (accept) begin
                valid_d = 1'b1;
                pc_d    = in_pc;
                reg1_d  = rdata1;
                reg2_d  = rdata2;
                sext_d  = sext;
                rs_d    = rs_f;
                rt_d    = rt_f;
                rd_d    = rd_f;
                ctrl_d  = in_ctrl;
            end else if (stall) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == RUN) && accept && in_halt)
            state_d = HALTED;
        halt_d = (state_q == HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            reg1_q  <= '0;
            reg2_q  <= '0;
            sext_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            sext_q  <= sext_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_reg1        = reg1_q;
    assign out_reg2        = reg2_q;
    assign out_sign_extend = sext_q;
    assign out_rs          = rs_q;
    assign out_rt          = rt_q;
    assign out_rd          = rd_q;
    assign out_ctrl        = ctrl_q;
    assign stall_flag      = stall;
    assign out_halt        = halt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - scoreboard bench for decode_pipe
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instruccion = '0;
    logic [21:0] in_ctrl = '0;
    logic        in_halt = 1'b0;
    logic        flush = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  write_register = '0;
    logic [31:0] write_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc, out_reg1, out_reg2, out_sign_extend;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [21:0] out_ctrl;
    logic        stall_flag;
    logic        out_halt;

    decode_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instruccion(in_instruccion), .in_ctrl(in_ctrl), .in_halt(in_halt),
        .flush(flush), .RegWrite(RegWrite), .write_register(write_register),
        .write_data(write_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_reg1(out_reg1), .out_reg2(out_reg2),
        .out_sign_extend(out_sign_extend), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_ctrl(out_ctrl), .stall_flag(stall_flag),
        .out_halt(out_halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, r1, r2, sx;
        logic [4:0]  rs, rt, rd;
        logic [21:0] ctrl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        RegWrite = 1'b1; write_register = r; write_data = d;
        @(posedge clk); #1;
        RegWrite = 1'b0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [15:0] imm, input logic [21:0] ctrl, input logic halt);
        in_pc = pc; in_instruccion = mk(rs, rt, imm); in_ctrl = ctrl; in_halt = halt; in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] imm, input logic [21:0] ctrl, input logic halt,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] sx);
        exp_t e;
        logic ok;
        present(pc, rs, rt, imm, ctrl, halt);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout pc=%h actual=in_ready_low required=accept", pc);
        end else begin
            e.pc = pc; e.r1 = r1; e.r2 = r2; e.sx = sx;
            e.rs = rs; e.rt = rt; e.rd = imm[15:11]; e.ctrl = ctrl;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_halt = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output actual=pc_%h required=none", out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_reg1", out_reg1, e.r1);
                chk("sb_reg2", out_reg2, e.r2);
                chk("sb_sext", out_sign_extend, e.sx);
                chk("sb_rs", {27'd0, out_rs}, {27'd0, e.rs});
                chk("sb_rt", {27'd0, out_rt}, {27'd0, e.rt});
                chk("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("sb_ctrl", {10'd0, out_ctrl}, {10'd0, e.ctrl});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_halt", {31'd0, out_halt}, 32'd0);
        chk("rst_stall", {31'd0, stall_flag}, 32'd0);
        chk("rst_out_ctrl", {10'd0, out_ctrl}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;

        wb(5'd1, 32'h1111_1111);
        wb(5'd2, 32'h2222_2222);
        wb(5'd3, 32'h3333_3333);
        wb(5'd8, 32'h8888_8888);

        send(32'h104, 5'd1, 5'd2, 16'h8001, 22'h000155, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_8001);

        // same-cycle writeback forwarded to rs
        RegWrite = 1'b1; write_register = 5'd5; write_data = 32'h0000_CAFE;
        send(32'h108, 5'd5, 5'd0, 16'h7FFF, 22'h03FFF0, 1'b0, 32'h0000_CAFE, 32'h0, 32'h0000_7FFF);
        RegWrite = 1'b0;

        // load-use: load rt=8 then consumer with rs=8
        send(32'h10C, 5'd0, 5'd8, 16'h0004, 22'h00000B, 1'b0, 32'h0, 32'h8888_8888, 32'h0000_0004);
        present(32'h180, 5'd8, 5'd3, 16'h1234, 22'h00F0F0, 1'b0);
        @(negedge clk);
        chk("stall_flag_hazard", {31'd0, stall_flag}, 32'd1);
        chk("in_ready_hazard", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_ctrl", {10'd0, out_ctrl}, 32'd0);
        send(32'h180, 5'd8, 5'd3, 16'h1234, 22'h00F0F0, 1'b0, 32'h8888_8888, 32'h3333_3333, 32'h0000_1234);

        // backpressure: ID/EX must hold for 3 cycles
        out_ready = 1'b0;
        present(32'h200, 5'd2, 5'd1, 16'hFFFF, 22'h200000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pc", out_pc, 32'h180);
            chk("hold_reg1", out_reg1, 32'h8888_8888);
            chk("hold_ctrl", {10'd0, out_ctrl}, 32'h0000_F0F0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h200, 5'd2, 5'd1, 16'hFFFF, 22'h200000, 1'b0, 32'h2222_2222, 32'h1111_1111, 32'hFFFF_FFFF);

        // flush with a pending load-use hazard and valid input
        send(32'h300, 5'd0, 5'd8, 16'h0000, 22'h000008, 1'b0, 32'h0, 32'h8888_8888, 32'h0);
        out_ready = 1'b0;
        flush = 1'b1;
        present(32'h304, 5'd8, 5'd3, 16'h0001, 22'h000004, 1'b0);
        @(negedge clk);
        chk("flush_stall", {31'd0, stall_flag}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ctrl", {10'd0, out_ctrl}, 32'd0);
        chk("flush_stall_after", {31'd0, stall_flag}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        void'(exp_q.pop_front());

        // register 0 ignores writes
        wb(5'd0, 32'h0000_FFFF);
        send(32'h400, 5'd0, 5'd5, 16'h0010, 22'h000001, 1'b0, 32'h0, 32'h0000_CAFE, 32'h0000_0010);

        // halt
        send(32'h500, 5'd1, 5'd2, 16'h0000, 22'h000002, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h0);
        chk("halt_out_halt_early", {31'd0, out_halt}, 32'd0);
        chk("halt_in_ready", {31'd0, in_ready}, 32'd0);
        present(32'h504, 5'd3, 5'd1, 16'h0002, 22'h000001, 1'b0);
        @(posedge clk); #1;
        chk("halt_out_halt", {31'd0, out_halt}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("halted_in_ready", {31'd0, in_ready}, 32'd0);
            chk("halted_out_halt", {31'd0, out_halt}, 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // mid-operation reset
        reset = 1'b0;
        #1;
        chk("areset_out_halt", {31'd0, out_halt}, 32'd0);
        chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("areset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        send(32'h600, 5'd1, 5'd2, 16'h8000, 22'h000003, 1'b0, 32'h0, 32'h0, 32'hFFFF_8000);
        repeat (2) @(negedge clk);
        chk("post_reset_stall", {31'd0, stall_flag}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter LEN, default 32, meaning data/instruction/PC width.
REQ-002 SHALL have parameter NREG, default 32, meaning register count; NB = $clog2(NREG).
REQ-003 SHALL have parameter CTRL_W, default 22, meaning width of the control bus {execute, memory, writeBack}.
REQ-004 SHALL have parameter MEM_READ_BIT, default 3, meaning index in the control bus that flags a load.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-008 SHALL have port in_ready  output  1  decode accepts the instruction this cycle.
REQ-009 SHALL have port in_pc  input  LEN  PC+4 of the incoming instruction.
REQ-010 SHALL have port in_instruccion  input  LEN  instruction word.
REQ-011 SHALL have port in_ctrl  input  CTRL_W  control bus from the control unit.
REQ-012 SHALL have port in_halt  input  1  incoming instruction is HALT.
REQ-013 SHALL have port flush  input  1  squash the instruction in decode and the ID/EX register.
REQ-014 SHALL have port RegWrite  input  1  writeback enable.
REQ-015 SHALL have port write_register  input  NB  writeback address.
REQ-016 SHALL have port write_data  input  LEN  writeback data.
REQ-017 SHALL have port out_valid  output  1  ID/EX holds a valid instruction.
REQ-018 SHALL have port out_ready  input  1  execute consumes ID/EX this cycle.
REQ-019 SHALL have port out_pc  output  LEN  registered PC+4.
REQ-020 SHALL have port out_reg1  output  LEN  registered rs operand.
REQ-021 SHALL have port out_reg2  output  LEN  registered rt operand.
REQ-022 SHALL have port out_sign_extend  output  LEN  registered sign-extended instr[15:0].
REQ-023 SHALL have port out_rs  output  NB  registered rs field.
REQ-024 SHALL have port out_rt  output  NB  registered rt field.
REQ-025 SHALL have port out_rd  output  NB  registered rd field.
REQ-026 SHALL have port out_ctrl  output  CTRL_W  registered control bus.
REQ-027 SHALL have port stall_flag  output  1  load-use bubble inserted this cycle.
REQ-028 SHALL have port out_halt  output  1  HALT has left decode; pipeline draining.

Function
REQ-029 SHALL hold NREG x LEN register file; register 0 reads 0, writes to it ignored; write on rising edge when RegWrite.
REQ-030 SHALL bypass write_data to a read port combinationally when RegWrite and write_register equals that nonzero read address.
REQ-031 SHALL raise hazard when out_valid, out_ctrl[MEM_READ_BIT], out_rt != 0, and out_rt equals instr[25:21] or instr[20:16].
REQ-032 SHALL define load_en = !out_valid || out_ready; in_ready = load_en && !hazard && state == RUN && !flush.
REQ-033 SHALL, when load_en and in_valid and in_ready, capture all out_* fields from the instruction and set out_valid=1.
REQ-034 SHALL, when load_en and hazard (state RUN, no flush), load a bubble: out_valid=0, out_ctrl=0, stall_flag=1 that cycle; instruction is held upstream.
REQ-035 SHALL, when load_en and no accept and no hazard, clear out_valid; when !load_en hold every out_* field.
REQ-036 SHALL, on flush, clear out_valid and out_ctrl next edge regardless of out_ready, deassert in_ready and stall_flag; flush beats hazard and halt.
REQ-037 SHALL run FSM RUN -> HALTED when an instruction with in_halt=1 is accepted; HALTED is terminal until reset; in_ready=0 in HALTED.
REQ-038 SHALL assert out_halt registered, one edge after entering HALTED, and hold it.
REQ-039 SHALL sign-extend instr[15:0] to LEN bits with bit 15 replicated.

Reset
REQ-040 SHALL, on reset low, asynchronously clear all registers, all out_* fields, out_valid, out_halt, and enter RUN; stall_flag=0.
REQ-041 SHALL discard any in-flight bubble or halt on mid-operation reset; first accept occurs on the first edge after reset deasserts.

Verification
REQ-042 SHALL test: RegWrite=1, write_register=5, write_data=0xCAFE, same-cycle accept reading rs=5 -> next edge out_reg1=0xCAFE.
REQ-043 SHALL test: load into rt=8 in ID/EX, next instruction rs=8 -> stall_flag=1, in_ready=0, out_valid=0 one cycle, then accept.
REQ-044 SHALL test: out_valid=1, out_ready=0 for 3 cycles -> all out_* stable, in_ready=0; out_ready=1 -> next instruction loaded.
REQ-045 SHALL test: flush=1 with hazard and valid input -> out_valid=0, out_ctrl=0, stall_flag=0 next edge.
REQ-046 SHALL test: write to register 0 with 0xFFFF, then read rs=0 -> out_reg1=0; in_halt accepted -> out_halt=1 one edge after HALTED, in_ready stays 0.
